// File: rtl/box_pkg.sv
// box_pkg: shared widths, FSM state type and slot-select helper
// for the box splitter and the overlay drawer.
package box_pkg;

  localparam int MAX_BOX_NUM = 10;
  localparam int BOX_WIDTH   = 38;
  localparam int IDX_W       = 4;
  localparam int BUS_W       = MAX_BOX_NUM * BOX_WIDTH;

  typedef logic [BOX_WIDTH-1:0] box_t;
  typedef logic [IDX_W-1:0]     idx_t;
  typedef logic [BUS_W-1:0]     bus_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_DONE
  } state_e;

  function automatic box_t slot_sel(bus_t all, idx_t idx);
    box_t r;
    r = '0;
    for (int k = 0; k < MAX_BOX_NUM; k++)
      if (idx == idx_t'(k))
        r = all[k*BOX_WIDTH +: BOX_WIDTH];
    return r;
  endfunction

endpackage

// File: rtl/box_splitter_if.sv
// box_splitter_if: serial box stream with valid/ready handshake.
// master drives the box, slave returns ready.
interface box_splitter_if;
  import box_pkg::*;

  logic box_valid_out;
  logic box_ready_in;
  box_t box_out;
  idx_t box_idx_out;
  logic box_last_out;

  modport master (
    output box_valid_out,
    output box_out,
    output box_idx_out,
    output box_last_out,
    input  box_ready_in
  );

  modport slave (
    input  box_valid_out,
    input  box_out,
    input  box_idx_out,
    input  box_last_out,
    output box_ready_in
  );

endinterface

// File: rtl/box_slot_mux.sv
// box_slot_mux: combinational index-to-slot selector on the flat box bus.
// Out-of-range indices select zero.
module box_slot_mux
  import box_pkg::*;
(
  input  bus_t box_all_in,
  input  idx_t idx_in,
  output box_t box_out
);

  assign box_out = slot_sel(box_all_in, idx_in);

endmodule

// File: rtl/box_splitter.sv
// box_splitter: snapshots the box bus on the vs_in fall and replays it as a stream.
// Define BOX_SPLITTER_SKIP_ZERO_EN to skip all-zero slots below the count.
module box_splitter
  import box_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           vs_in,
  input  idx_t           box_count_in,
  input  bus_t           box_all_in,
  box_splitter_if.master bo,
  output logic           busy_out,
  output logic           frame_done_out,
  output logic           frame_drop_out
);

  state_e state_q, state_d;
  logic   vs_q;
  logic   valid_q, valid_d;
  idx_t   idx_q, idx_d;
  idx_t   cnt_q, cnt_d;
  bus_t   snap_q, snap_d;
  logic   done_q, done_d;
  logic   drop_q, drop_d;

  logic   cap;
  logic   accept;
  logic   last;
  logic   hit0, hit1;
  idx_t   nxt0, nxt1;
  idx_t   cnt_clamp;
  box_t   box_w;

  logic [MAX_BOX_NUM-1:0] use_w;
  logic [MAX_BOX_NUM-1:0] after_w;

  assign cap    = vs_q & ~vs_in;
  assign accept = valid_q & bo.box_ready_in;

  assign cnt_clamp = (box_count_in > idx_t'(MAX_BOX_NUM)) ?
                     idx_t'(MAX_BOX_NUM) : box_count_in;

  // use_w marks slots that get presented; after_w those beyond the current one
  for (genvar g = 0; g < MAX_BOX_NUM; g++) begin : g_use
    localparam idx_t GI = idx_t'(g);
`ifdef BOX_SPLITTER_SKIP_ZERO_EN
    assign use_w[g] = (GI < cnt_q) &&
                      (snap_q[g*BOX_WIDTH +: BOX_WIDTH] != '0);
`else
    assign use_w[g] = GI < cnt_q;
`endif
    assign after_w[g] = use_w[g] && (GI > idx_q);
  end

  function automatic logic [IDX_W:0] first_set(
    logic [MAX_BOX_NUM-1:0] v
  );
    logic [IDX_W:0] r;
    r = '0;
    for (int k = MAX_BOX_NUM - 1; k >= 0; k--)
      if (v[k])
        r = {1'b1, idx_t'(k)};
    return r;
  endfunction

  assign {hit0, nxt0} = first_set(use_w);
  assign {hit1, nxt1} = first_set(after_w);
  assign last = ~hit1;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    drop_d  = 1'b0;
    if (cap) begin
      snap_d = box_all_in;
      cnt_d  = cnt_clamp;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (cap)
          state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (cap) begin
          drop_d = 1'b1;
        end else if (hit0) begin
          idx_d   = nxt0;
          valid_d = 1'b1;
          state_d = ST_SEND;
        end else begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_SEND: begin
        if (accept && last) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (accept) begin
          idx_d = nxt1;
        end
        // a new frame wins; completing the last box still counts as done
        if (cap) begin
          valid_d = 1'b0;
          drop_d  = ~(accept && last);
          state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        state_d = cap ? ST_LOAD : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vs_q    <= 1'b0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      snap_q  <= '0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vs_q    <= vs_in;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  box_slot_mux u_mux (
    .box_all_in (snap_q),
    .idx_in     (idx_q),
    .box_out    (box_w)
  );

  assign bo.box_valid_out = valid_q;
  assign bo.box_out       = box_w;
  assign bo.box_idx_out   = idx_q;
  assign bo.box_last_out  = valid_q & last;

  assign busy_out       = (state_q == ST_LOAD) || (state_q == ST_SEND);
  assign frame_done_out = done_q;
  assign frame_drop_out = drop_q;

endmodule

// File: tb/tb_box_splitter.sv
// tb_box_splitter: random frames against a queue model of the replayed stream.
// Build with BOX_SPLITTER_SKIP_ZERO_EN to match the skip-zero RTL variant.
module tb_box_splitter;
  import box_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic vs_in;
  idx_t box_count_in;
  bus_t box_all_in;
  logic busy_out;
  logic frame_done_out;
  logic frame_drop_out;

  box_splitter_if bo();

  box_splitter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .vs_in          (vs_in),
    .box_count_in   (box_count_in),
    .box_all_in     (box_all_in),
    .bo             (bo),
    .busy_out       (busy_out),
    .frame_done_out (frame_done_out),
    .frame_drop_out (frame_drop_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   idx;
    box_t data;
    bit   last;
  } exp_t;

  exp_t exp_q[$];
  box_t slot[MAX_BOX_NUM];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic box_t rand_box();
    return box_t'({$urandom, $urandom});
  endfunction

  task automatic rand_slots(input int zero_odds);
    for (int k = 0; k < MAX_BOX_NUM; k++) begin
      slot[k] = rand_box();
      if (zero_odds > 0 && $urandom_range(zero_odds - 1) == 0)
        slot[k] = '0;
    end
  endtask

  task automatic build(input int cnt);
    int   n;
    exp_t e;
    n = (cnt > MAX_BOX_NUM) ? MAX_BOX_NUM : cnt;
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
`ifdef BOX_SPLITTER_SKIP_ZERO_EN
      if (slot[k] == '0) continue;
`endif
      e.idx  = k;
      e.data = slot[k];
      e.last = 1'b0;
      exp_q.push_back(e);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_back();
      e.last = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  // called on a negedge; the capture edge is the next posedge
  task automatic fire(input int cnt);
    vs_in = 1'b1;
    @(negedge clk);
    for (int k = 0; k < MAX_BOX_NUM; k++)
      box_all_in[k*BOX_WIDTH +: BOX_WIDTH] = slot[k];
    box_count_in = idx_t'(cnt);
    vs_in = 1'b0;
    build(cnt);
  endtask

  task automatic watch(input bit exp_drop, input int rdy_pct,
                       input int hold, input int stop);
    bit fin;
    int lim;
    fin = 1'b0;
    lim = (stop > 0) ? stop : 300;
    @(negedge clk);
    for (int k = 0; k < MAX_BOX_NUM; k++)
      box_all_in[k*BOX_WIDTH +: BOX_WIDTH] = rand_box();
    box_count_in = idx_t'($urandom);
    chk("load_drop", frame_drop_out, exp_drop);
    chk("load_busy", busy_out, 1);
    chk("load_valid", bo.box_valid_out, 0);
    bo.box_ready_in = $urandom_range(1);
    for (int c = 0; c < lim && !fin; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        chk("done", frame_done_out, 1);
        chk("end_valid", bo.box_valid_out, 0);
        chk("end_busy", busy_out, 0);
        fin = 1'b1;
      end else begin
        chk("no_done", frame_done_out, 0);
        chk("no_drop", frame_drop_out, 0);
        chk("busy", busy_out, 1);
`ifndef BOX_SPLITTER_SKIP_ZERO_EN
        chk("valid", bo.box_valid_out, 1);
`endif
        if (bo.box_valid_out) begin
          chk("idx", 64'(bo.box_idx_out), 64'(exp_q[0].idx));
          chk("box", 64'(bo.box_out), 64'(exp_q[0].data));
          chk("last", bo.box_last_out, exp_q[0].last);
        end
        bo.box_ready_in = (c >= hold) && ($urandom_range(99) < rdy_pct);
        if (bo.box_valid_out && bo.box_ready_in)
          void'(exp_q.pop_front());
      end
    end
    if (stop == 0) begin
      if (!fin)
        chk("timeout", 0, 1);
      @(negedge clk);
      chk("idle_done", frame_done_out, 0);
      chk("idle_busy", busy_out, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    vs_in = 1'b0;
    box_count_in = '0;
    box_all_in = '0;
    bo.box_ready_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", bo.box_valid_out, 0);
    chk("rst_box", 64'(bo.box_out), 0);
    chk("rst_idx", 64'(bo.box_idx_out), 0);
    chk("rst_last", bo.box_last_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_done", frame_done_out, 0);
    chk("rst_drop", frame_drop_out, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // basic replay
    rand_slots(0);
    slot[0] = 38'h1;
    slot[1] = 38'h2;
    slot[2] = 38'h3;
    fire(3);
    watch(1'b0, 100, 0, 0);

    // backpressure
    rand_slots(0);
    slot[0] = 38'h1;
    slot[1] = 38'h2;
    fire(2);
    watch(1'b0, 100, 5, 0);

    // empty frame and clamped count
    rand_slots(0);
    fire(0);
    watch(1'b0, 100, 0, 0);
    rand_slots(0);
    fire(15);
    watch(1'b0, 100, 0, 0);

    // abort: second vs fall during SEND
    rand_slots(0);
    fire(10);
    watch(1'b0, 0, 0, 5);
    rand_slots(0);
    fire(10);
    watch(1'b1, 70, 0, 0);

    // reset while presenting idx 4
    rand_slots(0);
    fire(8);
    watch(1'b0, 100, 0, 5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bo.box_valid_out, 0);
    chk("mid_rst_box", 64'(bo.box_out), 0);
    chk("mid_rst_idx", 64'(bo.box_idx_out), 0);
    chk("mid_rst_last", bo.box_last_out, 0);
    chk("mid_rst_busy", busy_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bo.box_ready_in = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("post_rst_done", frame_done_out, 0);
    chk("post_rst_drop", frame_drop_out, 0);
    chk("post_rst_busy", busy_out, 0);
    rand_slots(0);
    fire(6);
    watch(1'b0, 100, 0, 0);

    // vs held high: nothing happens until it falls
    vs_in = 1'b1;
    repeat (20) @(negedge clk);
    chk("vs_hi_busy", busy_out, 0);
    chk("vs_hi_valid", bo.box_valid_out, 0);
    rand_slots(0);
    fire(4);
    watch(1'b0, 100, 0, 0);

    // zero slots below count
    rand_slots(0);
    slot[0] = 38'h5;
    slot[1] = '0;
    slot[2] = 38'h7;
    slot[3] = '0;
    fire(4);
    watch(1'b0, 100, 0, 0);

    for (int f = 0; f < 25; f++) begin
      rand_slots(3);
      fire($urandom_range(15));
      watch(1'b0, $urandom_range(30, 100), $urandom_range(3), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/box_splitter.md
Name: box_splitter

Overview:
- Reader-side counterpart of the per-frame box collector.
- Snapshots the flat box bus and box count once per frame, at the end of the vs_in pulse.
- Replays the boxes one at a time over a valid/ready stream. Downstream consumers (overlay drawer, UART reporter) therefore see a serial box stream that is stable for the whole frame.
- Sits between the box collector output and any per-box consumer.

Parameters:
- MAX_BOX_NUM, 10, slot count in the flat input bus; box 0 is at the LSBs.
- BOX_WIDTH, 38, bits per box; contents are opaque to this block.
- IDX_W, 4, width of the box count and box index; must satisfy 2^IDX_W > MAX_BOX_NUM.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- vs_in  in  1  frame sync, level; the high-to-low transition triggers a capture
- box_count_in  in  IDX_W  valid box count for the finished frame
- box_all_in  in  MAX_BOX_NUM*BOX_WIDTH  flat box bus; slot k is at bits [k*BOX_WIDTH +: BOX_WIDTH]
- box_valid_out  out  1  box_out, box_idx_out and box_last_out are valid
- box_ready_in  in  1  downstream accepts the current box
- box_out  out  BOX_WIDTH  current box
- box_idx_out  out  IDX_W  slot index of the current box
- box_last_out  out  1  current box is the final box of this frame
- busy_out  out  1  a frame is being replayed (LOAD or SEND)
- frame_done_out  out  1  one-cycle pulse when replay of a frame completes, including 0-box frames
- frame_drop_out  out  1  one-cycle pulse when a replay is aborted by a new capture

Behaviour:
- Reset: all outputs 0; internal vs_d = 0; FSM = IDLE; snapshot registers cleared.
- Capture event (cap): vs_d == 1 and vs_in == 0 at a rising clk edge. vs_d is vs_in registered.
- At the cap edge, box_all_in and box_count_in are registered into the snapshot.
  - Pre-edge values are taken, so a box written by the collector on that same edge belongs to the next frame.
  - Count is clamped: a value above MAX_BOX_NUM is stored as MAX_BOX_NUM.
- FSM states: IDLE, LOAD, SEND, DONE.
- IDLE:
  - on cap go to LOAD.
- LOAD (one cycle):
  - count == 0: go to DONE.
  - otherwise: idx = 0, assert box_valid_out, go to SEND.
- Output timing: first box_valid_out is high exactly 2 cycles after the cap edge (cap edge, LOAD edge).
- SEND:
  - box_out = snapshot slot idx; box_idx_out = idx; box_last_out = (idx == count-1).
  - While box_valid_out && !box_ready_in, all of box_out, box_idx_out and box_last_out are held stable.
  - On box_valid_out && box_ready_in with the last box: drop valid, go to DONE.
  - On box_valid_out && box_ready_in otherwise: idx+1 and present the next box with valid in the following cycle. This gives one box per cycle under constant ready.
- DONE: frame_done_out = 1 for one cycle, go to IDLE.
- busy_out = 1 in LOAD and SEND.
- New cap while in LOAD or SEND:
  - pulse frame_drop_out, resnapshot, go to LOAD.
  - The current box is not completed; valid drops at that edge.
  - If the cap coincides with acceptance of the last box, that frame counts as completed: frame_done_out pulses, no drop. The new frame's capture/LOAD proceeds in the same edge as if from IDLE.
- Cap in DONE: frame_done_out still pulses; go to LOAD.
- vs_in held high indefinitely: no capture, FSM idles.
- Reset asserted mid-replay: immediate return to reset values; no done or drop pulse.
- box_ready_in is ignored when box_valid_out = 0.

Optional Feature:
- Macro: BOX_SPLITTER_SKIP_ZERO_EN.
- Defined:
  - Slots with index < count whose value is all-zero are skipped and never presented.
  - box_idx_out still reports the original slot index.
  - box_last_out marks the last non-zero slot below count.
  - If all such slots are zero, the frame behaves as count == 0.
  - Skipping may insert idle (valid-low) cycles between boxes.
- Not defined: every slot below count is presented, zeros included.

Decomposition:
- Shared package box_pkg:
  - MAX_BOX_NUM, BOX_WIDTH, IDX_W defaults.
  - FSM state enum.
  - Box slot-select helper function.
- One natural sub-module: box_slot_mux. It is a combinational index-to-slot selector and is reused by the overlay drawer.

Test Plan:
- Basic replay: count=3, slots 0..2 = 38'h1,38'h2,38'h3, ready held 1 -> valid for 3 consecutive cycles starting 2 cycles after the vs fall; idx 0,1,2; last only on idx 2; frame_done_out pulse the cycle after.
- Backpressure: count=2, ready low for 5 cycles after valid -> box_out=38'h1, idx 0 stable all 5 cycles; both boxes delivered in order once ready rises.
- Empty and clamp:
  - count=0 -> no valid; frame_done_out pulses 2 cycles after the cap.
  - count=15 -> exactly 10 boxes, last on idx 9.
- Abort: count=10, ready=0, second vs pulse falls during SEND -> frame_drop_out one pulse; new snapshot replayed from idx 0 with new data.
- Reset mid-SEND: rst_n low for 1 cycle at idx 4 -> all outputs 0 immediately; no done/drop pulse; next vs fall replays normally.
- With BOX_SPLITTER_SKIP_ZERO_EN: count=4, slots = 38'h5,0,38'h7,0 -> boxes idx 0 then idx 2, last on idx 2; without the macro, 4 boxes.
